// File: rtl/seq_match_if.sv
// Record handshake bundle between the match logger and its consumer.
// The master side produces records and the slave side accepts them.
interface seq_match_if #(
  parameter int TS_W  = 16,
  parameter int GAP_W = 8
);
  logic             rec_valid;
  logic             rec_ready;
  logic [TS_W-1:0]  rec_ts;
  logic [GAP_W-1:0] rec_gap;

  modport master (output rec_valid, rec_ts, rec_gap, input rec_ready);
  modport slave  (input rec_valid, rec_ts, rec_gap, output rec_ready);
endinterface

// File: rtl/seq_match_logger.sv
// Match logger: turns rising edges of the detector output into
// {timestamp, gap} records, queues them in a small first-word-fall-through
// FIFO drained over valid/ready, and keeps a saturating match count plus a
// sticky drop flag.
module seq_match_logger #(
  parameter int TS_W  = 16,
  parameter int GAP_W = 8,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   det,
  input  logic                   clr,
  seq_match_if.master            rec,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   ovf
);
  localparam int AW = $clog2(DEPTH);

  logic             det_q;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      lvl_q, lvl_d;
  logic [TS_W-1:0]  ts_mem_q  [DEPTH];
  logic [GAP_W-1:0] gap_mem_q [DEPTH];

  logic rise, pop, full, push, wr_en;

  function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] v);
    return (v == '1) ? v : v + GAP_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Next-state decode: edge detect, FIFO bookkeeping, counters; clr overrides.
  always_comb begin
    rise  = det & ~det_q;
    pop   = (lvl_q != '0) & rec.rec_ready;
    full  = (lvl_q == (AW + 1)'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push  = rise & (~full | pop);
    wr_en = push & ~clr;

    ts_d  = ts_q + TS_W'(1);
    gap_d = rise ? GAP_W'(1) : gap_sat_inc(gap_q);
    cnt_d = rise ? cnt_sat_inc(cnt_q) : cnt_q;
    ovf_d = ovf_q | (rise & full & ~pop);
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + (AW + 1)'(1);
      2'b01:   lvl_d = lvl_q - (AW + 1)'(1);
      default: lvl_d = lvl_q;
    endcase

    if (clr) begin
      ts_d  = '0;
      gap_d = '1;
      cnt_d = '0;
      ovf_d = 1'b0;
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end
  end

  // State registers and record storage; everything clears on async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_q <= 1'b0;
      ts_q  <= '0;
      gap_q <= '1;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ts_mem_q[i]  <= '0;
        gap_mem_q[i] <= '0;
      end
    end else begin
      det_q <= det;
      ts_q  <= ts_d;
      gap_q <= gap_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      if (wr_en) begin
        ts_mem_q[wr_q]  <= ts_q;
        gap_mem_q[wr_q] <= gap_q;
      end
    end
  end

  assign rec.rec_valid = (lvl_q != '0);
  assign rec.rec_ts    = ts_mem_q[rd_q];
  assign rec.rec_gap   = gap_mem_q[rd_q];
  assign fifo_level    = lvl_q;
  assign match_cnt     = cnt_q;
  assign ovf           = ovf_q;
endmodule
